// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: four-digit multiplexed display front end.
// Converts a 14-bit binary value to BCD with a sequential shift-add-3
// converter, then scans the digits onto a shared bcd bus with
// active-low anodes.
// Optional feature macro: DISP_LZB_EN (leading-zero blanking).
module disp_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] value,
    input  logic        load,
    output logic        busy,
    output logic [3:0]  bcd,
    output logic [3:0]  an,
    output logic        overflow
);

    localparam int unsigned VW     = 14;
    localparam int unsigned BW     = 16;
    localparam int unsigned SW     = BW + VW;
    localparam int unsigned CW     = 4;
    localparam int unsigned PW     = 21;
    localparam int unsigned NSHIFT = 14;
    localparam int unsigned VMAX   = 9999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    logic [SW-1:0] sr;
    logic [SW-1:0] sr_adj;
    logic [CW-1:0] cnt;
    logic          big;
    logic [BW-1:0] disp;
    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [3:0]    sel_n;
    logic [3:0]    blank;

    // Add-3 correction of every BCD nibble >= 5; carries stay inside the nibble
    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < 4; i++) begin
            if (sr[VW + 4*i +: 4] >= 4'd5) begin
                sr_adj[VW + 4*i +: 4] = sr[VW + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Converter FSM; display register only changes when a result is complete
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sr       <= '0;
            cnt      <= '0;
            big      <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            disp     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        sr    <= {BW'(0), value};
                        cnt   <= '0;
                        big   <= (value > VW'(VMAX));
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // 14 shifts, then one settle cycle so the result lands at load+16
                    if (cnt == CW'(NSHIFT)) begin
                        state <= DONE;
                    end else begin
                        sr  <= {sr_adj[SW-2:0], 1'b0};
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    disp     <= big ? 16'hAAAA : sr[SW-1:VW];
                    overflow <= big;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One-hot-low select for the current scan index
    always_comb begin
        sel_n = ~(4'b0001 << idx);
    end

`ifdef DISP_LZB_EN
    // Blank digits above the most-significant non-zero digit; digit 0 always lit
    always_comb begin
        blank = 4'b0000;
        if (!overflow) begin
            if (disp[15:12] == 4'h0) blank[3] = 1'b1;
            if (disp[15:8]  == 8'h0) blank[2] = 1'b1;
            if (disp[15:4]  == 12'h0) blank[1] = 1'b1;
        end
    end
`else
    // All digits always lit
    always_comb begin
        blank = 4'b0000;
    end
`endif

    // Free-running prescaler, digit index and registered scan outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
            an    <= 4'b1111;
            bcd   <= 4'h0;
        end else begin
            if (presc == PW'(REFRESH_DIV - 1)) begin
                presc <= '0;
                idx   <= idx + 2'd1;
            end else begin
                presc <= presc + PW'(1);
            end
            an  <= sel_n | blank;
            bcd <= disp[{idx, 2'b00} +: 4];
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: one instance scanning every 4 cycles
// and one scanning every cycle, both checked each cycle against a reference
// model; conversion results go through a scoreboard queue.
module tb_disp_scan_ctrl;

    localparam int unsigned DIV = 4;

    typedef struct packed {
        logic [15:0] d;
        logic        o;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [13:0] value = '0;

    logic        busy4, ovf4, busy1, ovf1;
    logic [3:0]  bcd4, an4, bcd1, an1;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_presc = 0;
    int          m_cnt = 0;
    logic [1:0]  m_idx4 = '0;
    logic [1:0]  m_idx1 = '0;
    logic [15:0] m_disp = '0;
    logic        m_ovf = 1'b0;
    logic [3:0]  m_an4 = 4'hF, m_bcd4 = 4'h0, m_an1 = 4'hF, m_bcd1 = 4'h0;
    res_t        sb[$];

    always #5 clk = ~clk;

    disp_scan_ctrl #(.REFRESH_DIV(DIV)) dut4 (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .busy(busy4), .bcd(bcd4), .an(an4), .overflow(ovf4)
    );

    disp_scan_ctrl #(.REFRESH_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .busy(busy1), .bcd(bcd1), .an(an1), .overflow(ovf1)
    );

    function automatic res_t expect_of(int v);
        res_t r;
        if (v > 9999) begin
            r.d = 16'hAAAA;
            r.o = 1'b1;
        end else begin
            r.d = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
            r.o = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [3:0] exp_an(logic [1:0] i, logic [15:0] d, logic o);
        logic [3:0] a;
        a = ~(4'b0001 << i);
`ifdef DISP_LZB_EN
        if (!o) begin
            if (d[15:12] == 4'h0) a[3] = 1'b1;
            if (d[15:8] == 8'h0) a[2] = 1'b1;
            if (d[15:4] == 12'h0) a[1] = 1'b1;
        end
`else
        if (o && d == 16'h0) a = a;
`endif
        return a;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one clock, update the model from the inputs seen at the edge, compare
    task automatic step();
        res_t r;
        @(posedge clk);
        if (rst) begin
            m_presc = 0;
            m_cnt   = 0;
            m_idx4  = '0;
            m_idx1  = '0;
            m_disp  = '0;
            m_ovf   = 1'b0;
            m_an4   = 4'hF;
            m_bcd4  = 4'h0;
            m_an1   = 4'hF;
            m_bcd1  = 4'h0;
            sb.delete();
        end else begin
            m_an4  = exp_an(m_idx4, m_disp, m_ovf);
            m_bcd4 = m_disp[{m_idx4, 2'b00} +: 4];
            m_an1  = exp_an(m_idx1, m_disp, m_ovf);
            m_bcd1 = m_disp[{m_idx1, 2'b00} +: 4];
            m_idx1 = m_idx1 + 2'd1;
            if (m_presc == int'(DIV) - 1) begin
                m_presc = 0;
                m_idx4  = m_idx4 + 2'd1;
            end else begin
                m_presc++;
            end
            if (m_cnt == 0) begin
                if (load) begin
                    sb.push_back(expect_of(int'(value)));
                    m_cnt = 1;
                end
            end else if (m_cnt == 16) begin
                if (sb.size() > 0) begin
                    r = sb.pop_front();
                    m_disp = r.d;
                    m_ovf  = r.o;
                end
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        #1;
        check("busy4", 16'(busy4), 16'(m_cnt != 0));
        check("ovf4",  16'(ovf4),  16'(m_ovf));
        check("an4",   16'(an4),   16'(m_an4));
        check("bcd4",  16'(bcd4),  16'(m_bcd4));
        check("busy1", 16'(busy1), 16'(m_cnt != 0));
        check("ovf1",  16'(ovf1),  16'(m_ovf));
        check("an1",   16'(an1),   16'(m_an1));
        check("bcd1",  16'(bcd1),  16'(m_bcd1));
    endtask

    task automatic do_load(input int v, input int after);
        value = 14'(v);
        load  = 1'b1;
        step();
        load  = 1'b0;
        repeat (after) step();
    endtask

    initial begin
        // reset held for three cycles, then scan zeros
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (20) step();

        // normal conversions
        do_load(1234, 40);
        do_load(9999, 40);

        // overflow and recovery
        do_load(10000, 40);
        do_load(16383, 40);
        do_load(0, 40);

        // load while busy is dropped
        value = 14'd42;
        load  = 1'b1;
        step();
        load  = 1'b0;
        repeat (4) step();
        value = 14'd7;
        load  = 1'b1;
        step();
        load  = 1'b0;
        repeat (40) step();

        // reset in the middle of a conversion
        do_load(5, 7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (20) step();

        // display never shows a partial result
        do_load(5678, 40);
        do_load(1, 40);

        // small values and zero, relevant to blanking builds
        do_load(7, 40);
        do_load(80, 40);
        do_load(0, 24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
